// File: rtl/prio_enc_arb_pkg.sv
// Shared definitions for the prio_enc_arb grant arbiter: mode constants,
// FSM state encoding and the onehot helper used to mask the granted index.
package prio_enc_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Upper bound on N supported by the onehot helper.
    localparam int unsigned MAX_N = 1024;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic logic [MAX_N-1:0] onehot(input int unsigned pos);
        logic [MAX_N-1:0] v;
        v      = '0;
        v[pos] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/prio_enc_arb_if.sv
// Request/grant bundle between request sources, consumer and the arbiter.
interface prio_enc_arb_if #(parameter int N = 8);

    localparam int W = $clog2(N);

    logic [N-1:0] REQ;
    logic         MODE;
    logic         ACK;
    logic [W-1:0] IDX;
    logic         VALID;
    logic [W-1:0] PTR;

    modport master (output REQ, output MODE, output ACK,
                    input  IDX, input  VALID, input  PTR);

    modport slave  (input  REQ, input  MODE, input  ACK,
                    output IDX, output VALID, output PTR);

endinterface

// File: rtl/prio_enc_arb_find.sv
// Combinational search: lowest set bit at or above start (rr=1), falling
// back to the lowest set bit overall; rr=0 forces an LSB-first search.
module prio_find_first #(
    parameter int N = 8
) (
    input  logic [N-1:0]         vec,
    input  logic [$clog2(N)-1:0] start,
    input  logic                 rr,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int W = $clog2(N);

    logic [W-1:0] idx_hi;
    logic [W-1:0] idx_lo;
    logic         found_hi;
    logic         found_lo;

    always_comb begin
        idx_hi   = '0;
        idx_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (vec[i] && !found_lo) begin
                idx_lo   = W'(i);
                found_lo = 1'b1;
            end
            if (vec[i] && rr && (i >= 32'(start)) && !found_hi) begin
                idx_hi   = W'(i);
                found_hi = 1'b1;
            end
        end
        idx = found_hi ? idx_hi : idx_lo;
        any = |vec;
    end

endmodule

// File: rtl/prio_enc_arb.sv
// Registered N-way priority arbiter with VALID/ACK handshake; fixed
// LSB-first or round-robin priority selected by MODE.
module prio_enc_arb
    import prio_enc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           CLK,
    input  logic           RST_N,
    prio_enc_arb_if.slave  bus
);

    localparam int W = $clog2(N);

    state_e         state_q, state_d;
    logic [W-1:0]   idx_q, idx_d;
    logic [W-1:0]   ptr_q, ptr_d;
    logic           valid_q, valid_d;

    logic [MAX_N-1:0] oh;
    logic [N-1:0]     grant_mask;
    logic [N-1:0]     find_vec;
    logic [W-1:0]     find_idx;
    logic             find_any;
    logic             rr;
    logic             xfer;

    // Search operand: raw REQ from IDLE, REQ minus the just-acked index on
    // a transfer; start is the already-updated pointer so back-to-back
    // grants see the advanced round-robin position.
    always_comb begin
        rr         = (bus.MODE == MODE_RR);
        xfer       = (state_q == ST_GRANT) && bus.ACK;
        oh         = onehot(32'(idx_q));
        grant_mask = oh[N-1:0];
        ptr_d      = ptr_q;
        if (xfer && rr) begin
            ptr_d = (idx_q == W'(N - 1)) ? '0 : idx_q + 1'b1;
        end
        find_vec = (state_q == ST_GRANT) ? (bus.REQ & ~grant_mask) : bus.REQ;
    end

    prio_find_first #(.N(N)) u_find (
        .vec   (find_vec),
        .start (ptr_d),
        .rr    (rr),
        .idx   (find_idx),
        .any   (find_any)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (find_any) begin
                    state_d = ST_GRANT;
                    idx_d   = find_idx;
                    valid_d = 1'b1;
                end
            end
            ST_GRANT: begin
                if (bus.ACK) begin
                    if (find_any) begin
                        idx_d = find_idx;
                    end else begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
        end
    end

    assign bus.IDX   = idx_q;
    assign bus.VALID = valid_q;
    assign bus.PTR   = ptr_q;

endmodule

// File: tb/tb_prio_enc_arb.sv
// Scoreboard bench for prio_enc_arb: N=8 and N=5 instances share control
// inputs; a behavioural model predicts each edge's outputs.
module tb_prio_enc_arb;

    logic clk;
    logic rst_n;

    prio_enc_arb_if #(.N(8)) if8 ();
    prio_enc_arb_if #(.N(5)) if5 ();

    prio_enc_arb #(.N(8)) dut8 (.CLK(clk), .RST_N(rst_n), .bus(if8.slave));
    prio_enc_arb #(.N(5)) dut5 (.CLK(clk), .RST_N(rst_n), .bus(if5.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int valid;
        int idx;
        int ptr;
    } exp_t;

    exp_t q8[$];
    exp_t q5[$];

    int tests_run = 0;
    int tests_failed = 0;

    // Reference state per instance: [0] is N=8, [1] is N=5.
    int m_n[2] = '{8, 5};
    int m_valid[2];
    int m_idx[2];
    int m_ptr[2];

    // Rotating scan: first set bit walking upward from start modulo n.
    function automatic int find_from(int n, int vec, int start);
        for (int k = 0; k < n; k++) begin
            int j;
            j = (start + k) % n;
            if (vec[j]) return j;
        end
        return 0;
    endfunction

    task automatic model_step(input int u, input logic rst, input int req,
                              input logic md, input logic ak);
        int n;
        int mvec;
        n = m_n[u];
        if (!rst) begin
            m_valid[u] = 0;
            m_idx[u]   = 0;
            m_ptr[u]   = 0;
        end else if (m_valid[u] == 0) begin
            if (req != 0) begin
                m_idx[u]   = find_from(n, req, md ? m_ptr[u] : 0);
                m_valid[u] = 1;
            end
        end else if (ak) begin
            if (md) m_ptr[u] = (m_idx[u] + 1) % n;
            mvec = req & ~(1 << m_idx[u]);
            if (mvec != 0) m_idx[u] = find_from(n, mvec, md ? m_ptr[u] : 0);
            else m_valid[u] = 0;
        end
    endtask

    task automatic step(input logic rst, input logic [7:0] r8, input logic [4:0] r5,
                        input logic md, input logic ak);
        exp_t e;
        rst_n    = rst;
        if8.REQ  = r8;
        if5.REQ  = r5;
        if8.MODE = md;
        if5.MODE = md;
        if8.ACK  = ak;
        if5.ACK  = ak;
        model_step(0, rst, int'(r8), md, ak);
        e.valid = m_valid[0]; e.idx = m_idx[0]; e.ptr = m_ptr[0];
        q8.push_back(e);
        model_step(1, rst, int'(r5), md, ak);
        e.valid = m_valid[1]; e.idx = m_idx[1]; e.ptr = m_ptr[1];
        q5.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: compares every presented edge against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q8.size() > 0) begin
                e = q8.pop_front();
                tests_run++;
                if ({if8.VALID, if8.IDX, if8.PTR} !== {1'(e.valid), 3'(e.idx), 3'(e.ptr)}) begin
                    tests_failed++;
                    $display("FAIL n8_out t=%0t got valid=%b idx=%0d ptr=%0d exp valid=%0d idx=%0d ptr=%0d",
                             $time, if8.VALID, if8.IDX, if8.PTR, e.valid, e.idx, e.ptr);
                end
            end
            if (q5.size() > 0) begin
                e = q5.pop_front();
                tests_run++;
                if ({if5.VALID, if5.IDX, if5.PTR} !== {1'(e.valid), 3'(e.idx), 3'(e.ptr)}) begin
                    tests_failed++;
                    $display("FAIL n5_out t=%0t got valid=%b idx=%0d ptr=%0d exp valid=%0d idx=%0d ptr=%0d",
                             $time, if5.VALID, if5.IDX, if5.PTR, e.valid, e.idx, e.ptr);
                end
            end
        end
    end

    initial begin
        int budget;
        // Reset held with all requests and ACK active, then release.
        repeat (3) step(1'b0, 8'hFF, 5'h1F, 1'b0, 1'b1);
        step(1'b1, 8'hFF, 5'h1F, 1'b0, 1'b0);

        // Fixed mode sticky grant.
        step(1'b1, 8'h00, 5'h00, 1'b0, 1'b1);
        step(1'b1, 8'b0010_1000, 5'b01000, 1'b0, 1'b0);
        repeat (5) step(1'b1, 8'h80, 5'h10, 1'b0, 1'b0);
        step(1'b1, 8'h80, 5'h10, 1'b0, 1'b1);
        step(1'b1, 8'h80, 5'h10, 1'b0, 1'b1);
        step(1'b1, 8'h80, 5'h10, 1'b0, 1'b0);
        step(1'b1, 8'h80, 5'h10, 1'b0, 1'b0);

        // Round-robin fairness; N=5 sees the sparse 10001 pattern.
        repeat (12) step(1'b1, 8'hFF, 5'b10001, 1'b1, 1'b1);

        // Reset mid-grant at IDX=5, PTR=3 with ACK high.
        step(1'b0, 8'h00, 5'h00, 1'b1, 1'b0);
        step(1'b1, 8'h04, 5'h04, 1'b1, 1'b0);
        step(1'b1, 8'h20, 5'h10, 1'b1, 1'b1);
        step(1'b0, 8'hFF, 5'h1F, 1'b1, 1'b1);

        // Mode switch with the pointer retained.
        step(1'b1, 8'h0C, 5'h0C, 1'b1, 1'b0);
        step(1'b1, 8'h0C, 5'h0C, 1'b1, 1'b1);
        step(1'b1, 8'h0C, 5'h0C, 1'b0, 1'b1);
        step(1'b1, 8'h0C, 5'h0C, 1'b1, 1'b1);
        step(1'b1, 8'h0C, 5'h0C, 1'b1, 1'b1);

        // Randomised traffic including idle ACKs, mode flips and resets.
        for (int i = 0; i < 400; i++) begin
            logic        r_rst;
            logic [7:0]  r8;
            logic [4:0]  r5;
            logic        r_md;
            logic        r_ak;
            r_rst = ($urandom_range(0, 99) >= 3);
            r8    = 8'($urandom);
            r5    = 5'($urandom);
            if ($urandom_range(0, 3) == 0) r8 = 8'h00;
            if ($urandom_range(0, 3) == 0) r5 = 5'h00;
            r_md  = ($urandom_range(0, 9) < 7) ? prio_enc_pkg::MODE_RR : prio_enc_pkg::MODE_FIXED;
            r_ak  = ($urandom_range(0, 9) < 6);
            step(r_rst, r8, r5, r_md, r_ak);
        end

        budget = 0;
        while ((q8.size() > 0 || q5.size() > 0) && budget < 10) begin
            @(posedge clk);
            #2;
            budget++;
        end
        if (q8.size() > 0 || q5.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain got %0d/%0d pending exp 0/0", q8.size(), q5.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/prio_enc_arb.md
Name: prio_enc_arb

Overview:
- Parametrised, registered successor to the team's combinational 8-to-3 LSB-first priority encoder.
- Takes N request lines and produces a registered binary index of the winning request, with a VALID/ACK handshake.
- Mode selects one of two priority schemes:
  - MODE=0: legacy fixed LSB-first priority.
  - MODE=1: round-robin priority.
- Sits between request sources (interrupt lines, channel-ready flags) and a consumer that services one index at a time.

Parameters:
- N, 8: number of request lines; legal range is N ≥ 2, and non-power-of-2 values are allowed.
- W, $clog2(N): index width. Localparam, derived from N, not overridable.

Ports:
- CLK    input   1   single clock; all logic updates on its rising edge.
- RST_N  input   1   synchronous, active-low reset, sampled on the rising edge of CLK.
- REQ    input   N   request vector; bit i set means requester i wants service. Level-sensitive.
- MODE   input   1   0 = fixed LSB-first priority; 1 = round-robin.
- ACK    input   1   consumer accepts the current IDX; meaningful only when VALID=1.
- IDX    output  W   registered index of the granted request.
- VALID  output  1   IDX holds a live grant.
- PTR    output  W   round-robin start pointer (debug/observability).

Behaviour:
- Reset (RST_N=0 at a rising edge): state goes to IDLE; IDX=0, VALID=0, PTR=0. Reset overrides all other inputs, including in-flight grants and ACK.
- Search function, find(vec, start):
  - In round-robin mode, returns the lowest set index ≥ start; if none, the lowest set index overall.
  - In fixed mode, start is forced to 0, which reproduces the legacy LSB-first encoder exactly.
- States:
  - IDLE: VALID=0.
    - If |REQ: next state is GRANT, IDX <= find(REQ, PTR), VALID <= 1.
    - Otherwise remain in IDLE; IDX holds its last value.
  - GRANT: VALID=1, and IDX is held stable while ACK=0.
    - The grant is sticky: IDX stays the same even if REQ[IDX] deasserts or higher-priority requests arrive.
  - GRANT with ACK=1 (the transfer cycle):
    - Pointer update: in MODE=1, PTR <= (IDX == N-1) ? 0 : IDX+1. In MODE=0, PTR is unchanged.
    - Compute M = REQ & ~onehot(IDX).
    - If |M: stay in GRANT with IDX <= find(M, new PTR). This gives back-to-back grants with no bubble.
    - Otherwise: go to IDLE with VALID <= 0.
- Latency:
  - REQ to VALID is 1 cycle from IDLE.
  - ACK to the next IDX is 1 cycle.
  - Throughput is 1 grant per cycle when requests are continuous.
- ACK while VALID=0 is ignored: no pointer change, no state change.
- MODE is sampled only at evaluation edges. A mode change during GRANT does not alter the held IDX, and PTR is retained across mode changes.
- Wrap-around: PTR and IDX never reach values ≥ N; PTR wraps from N-1 to 0. Indices in the range N..2^W-1 are never produced.
- A requester granted and acked in the same window is masked for one evaluation only. If it is the sole requester, VALID drops for one cycle and the requester is re-granted on the following cycle.
- No combinational path from any input to any output; all outputs are registers.

Decomposition:
- Package prio_enc_pkg holds:
  - the MODE_FIXED=1'b0 and MODE_RR=1'b1 constants;
  - the state encoding (ST_IDLE, ST_GRANT);
  - a function for the onehot-mask computation.
- One sub-module, prio_find_first (combinational, parametrised by N). Inputs: vec[N-1:0], start[W-1:0], rr. Outputs: idx[W-1:0], any.
  - It is instantiated once in the top level.
  - It is verified standalone against an exhaustive reference model for N=8.

Test Plan:
1. Reset: hold RST_N=0 with REQ=8'hFF and ACK=1 for 3 cycles -> VALID=0, IDX=0, PTR=0 on every edge. Release reset -> VALID=1, IDX=0 on the next edge.
2. Fixed mode, sticky grant:
   - Drive MODE=0, REQ=8'b0010_1000 -> next edge VALID=1, IDX=3.
   - Change REQ to 8'h80 and hold ACK=0 for 5 cycles -> IDX stays 3.
   - Pulse ACK -> next edge IDX=7, VALID=1.
   - ACK again with REQ=8'h80 -> VALID=0, then the cycle after VALID=1, IDX=7.
3. Round-robin fairness: MODE=1, REQ=8'hFF held, ACK=1 every cycle -> IDX sequence 0,1,2,3,4,5,6,7,0,1; PTR trails IDX+1 mod 8.
4. Non-power-of-2: N=5, MODE=1, REQ=5'b10001, ACK every cycle -> IDX alternates 0,4,0,4; PTR goes 1,0,1,0 and never exceeds 4.
5. Reset mid-grant: in GRANT with IDX=5, PTR=3, assert RST_N=0 for 1 cycle with ACK=1 -> next edge VALID=0, IDX=0, PTR=0 (no pointer advance from the ACK).
6. Mode switch:
   - MODE=1, REQ=8'h0C, ack once (IDX=2, then PTR=3).
   - Switch to MODE=0 and ack -> next grant IDX is found LSB-first from the masked vector; PTR stays at 3.
   - Switch back to MODE=1 -> search resumes from PTR=3.
